// File: rtl/regressive_timer_pkg.sv
// Shared types and constants for the MM:SS regressive timer.
package regressive_timer_pkg;

    // Timer control states; the encoding is fixed here so the top and any
    // debug tooling agree on it.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Largest legal values of a plain decimal digit and of the seconds-tens digit.
    localparam int DIGIT_MAX    = 9;
    localparam int SEC_TENS_MAX = 5;

    // Bit positions of each BCD digit inside the 16-bit {MM,SS} word.
    localparam int DIGIT_W       = 4;
    localparam int SEC_UNITS_LSB = 0;
    localparam int SEC_TENS_LSB  = 4;
    localparam int MIN_UNITS_LSB = 8;
    localparam int MIN_TENS_LSB  = 12;

    // Clamp a loaded digit to its largest legal value.
    function automatic logic [3:0] sat_digit(input logic [3:0] value, input logic [3:0] max_value);
        logic [3:0] result;
        if (value > max_value) begin
            result = max_value;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/regressive_timer_digit.sv
// One BCD down-counting digit with saturating load and a combinational
// borrow output for chaining into the next more significant digit.
module bcd_down_digit
    import regressive_timer_pkg::*;
#(
    parameter int MAX_DIGIT = DIGIT_MAX
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dec_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic [3:0] digit_o,
    output logic       borrow_o
);

    localparam logic [3:0] MAX_L = 4'(MAX_DIGIT);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    // Next digit value: load wins over decrement; decrementing 0 wraps to the max.
    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = sat_digit(load_val_i, MAX_L);
        end else if (dec_i) begin
            if (digit_q == 4'd0) begin
                digit_d = MAX_L;
            end else begin
                digit_d = digit_q - 4'd1;
            end
        end else begin
            digit_d = digit_q;
        end
    end

    // Digit register with synchronous reset to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o  = digit_q;
    assign borrow_o = dec_i && !load_i && (digit_q == 4'd0);

endmodule

// File: rtl/regressive_timer.sv
// MM:SS countdown timer driven by a one-second tick; owns the control FSM,
// tick edge qualification and zero detection.
module regressive_timer
    import regressive_timer_pkg::*;
#(
    parameter int MAX_MIN_TENS = 9,
    parameter bit TICK_EDGE    = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        load,
    input  logic        start,
    input  logic        pause,
    input  logic [15:0] preset_bcd,
    output logic [15:0] count_bcd,
    output logic        tick_enable,
    output logic        running,
    output logic        done
);

    state_e      state_q;
    state_e      state_d;
    logic        tick_q;
    logic        tick_acc_s;
    logic        dec_s;
    logic        borrow_su_s;
    logic        borrow_st_s;
    logic        borrow_mu_s;
    logic        underflow_s;
    logic [15:0] count_s;
    logic        count_zero_s;
    logic        count_one_s;
    logic        running_q;
    logic        tick_enable_q;
    logic        done_q;

    // Qualify the tick: either its rising edge or its level, per TICK_EDGE.
    always_comb begin
        if (TICK_EDGE) begin
            tick_acc_s = tick && !tick_q;
        end else begin
            tick_acc_s = tick;
        end
    end

    // A tick only counts while RUNNING and is dropped when load or pause coincide.
    assign dec_s = (state_q == ST_RUNNING) && tick_acc_s && !load && !pause;

    bcd_down_digit #(.MAX_DIGIT(DIGIT_MAX)) u_sec_units (
        .clock(clock), .reset(reset), .dec_i(dec_s), .load_i(load),
        .load_val_i(preset_bcd[SEC_UNITS_LSB +: DIGIT_W]),
        .digit_o(count_s[SEC_UNITS_LSB +: DIGIT_W]), .borrow_o(borrow_su_s)
    );

    bcd_down_digit #(.MAX_DIGIT(SEC_TENS_MAX)) u_sec_tens (
        .clock(clock), .reset(reset), .dec_i(borrow_su_s), .load_i(load),
        .load_val_i(preset_bcd[SEC_TENS_LSB +: DIGIT_W]),
        .digit_o(count_s[SEC_TENS_LSB +: DIGIT_W]), .borrow_o(borrow_st_s)
    );

    bcd_down_digit #(.MAX_DIGIT(DIGIT_MAX)) u_min_units (
        .clock(clock), .reset(reset), .dec_i(borrow_st_s), .load_i(load),
        .load_val_i(preset_bcd[MIN_UNITS_LSB +: DIGIT_W]),
        .digit_o(count_s[MIN_UNITS_LSB +: DIGIT_W]), .borrow_o(borrow_mu_s)
    );

    bcd_down_digit #(.MAX_DIGIT(MAX_MIN_TENS)) u_min_tens (
        .clock(clock), .reset(reset), .dec_i(borrow_mu_s), .load_i(load),
        .load_val_i(preset_bcd[MIN_TENS_LSB +: DIGIT_W]),
        .digit_o(count_s[MIN_TENS_LSB +: DIGIT_W]), .borrow_o(underflow_s)
    );

    // The only value that decrements to 0000 is 0001, so that is the
    // "reaches zero this tick" condition.
    assign count_zero_s = (count_s == 16'h0000);
    assign count_one_s  = (count_s == 16'h0001);

    // Next-state logic with command priority load > pause > start > tick.
    // An underflow out of min_tens cannot happen while RUNNING; if it ever
    // did, the timer parks in DONE rather than keep counting garbage.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSED: begin
                    if (start && !pause) begin
                        if (count_zero_s) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RUNNING;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_RUNNING: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (dec_s && (count_one_s || underflow_s)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, tick history and registered output decodes.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            tick_q        <= 1'b0;
            running_q     <= 1'b0;
            tick_enable_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick;
            running_q     <= (state_d == ST_RUNNING);
            tick_enable_q <= (state_d == ST_RUNNING);
            done_q        <= (state_d == ST_DONE);
        end
    end

    assign count_bcd   = count_s;
    assign tick_enable = tick_enable_q;
    assign running     = running_q;
    assign done        = done_q;

endmodule

// File: tb/tb_regressive_timer.sv
// Self-checking bench for regressive_timer: directed scenarios plus random
// stimulus, all compared against a seconds-based reference model.
module tb_regressive_timer;

    logic        clock = 1'b0;
    logic        reset;
    logic        tick;
    logic        load;
    logic        start;
    logic        pause;
    logic [15:0] preset_bcd;
    logic [15:0] count_bcd;
    logic        tick_enable;
    logic        running;
    logic        done;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining time in seconds plus an abstract mode.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_secs  = 0;
    int m_mode  = M_IDLE;
    bit m_tprev = 1'b0;

    regressive_timer #(.MAX_MIN_TENS(9), .TICK_EDGE(1'b1)) dut (
        .clock(clock), .reset(reset), .tick(tick), .load(load), .start(start),
        .pause(pause), .preset_bcd(preset_bcd), .count_bcd(count_bcd),
        .tick_enable(tick_enable), .running(running), .done(done)
    );

    // 50 MHz clock.
    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Saturated preset converted to a count of seconds.
    function automatic int preset_secs(input logic [15:0] p);
        int mt, mu, st, su;
        mt = clamp(int'(p[15:12]), 9);
        mu = clamp(int'(p[11:8]), 9);
        st = clamp(int'(p[7:4]), 5);
        su = clamp(int'(p[3:0]), 9);
        return (mt * 10 + mu) * 60 + st * 10 + su;
    endfunction

    function automatic logic [15:0] to_bcd(input int secs);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Advance the model one clock using the rules of the timer.
    task automatic model_step(input bit r, input bit l, input bit s, input bit p,
                              input bit t, input logic [15:0] pre);
        bit acc;
        acc = t && !m_tprev;
        if (r) begin
            m_secs = 0; m_mode = M_IDLE; m_tprev = 1'b0;
        end else begin
            m_tprev = t;
            if (l) begin
                m_secs = preset_secs(pre); m_mode = M_IDLE;
            end else if (m_mode == M_RUN && p) begin
                m_mode = M_PAUSE;
            end else if ((m_mode == M_IDLE || m_mode == M_PAUSE) && s && !p) begin
                m_mode = (m_secs == 0) ? M_DONE : M_RUN;
            end else if (m_mode == M_RUN && acc) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) m_mode = M_DONE;
            end
        end
    endtask

    // Drive one cycle of inputs, clock, then compare all outputs to the model.
    task automatic step(input bit r, input bit l, input bit s, input bit p,
                        input bit t, input logic [15:0] pre);
        reset = r; load = l; start = s; pause = p; tick = t; preset_bcd = pre;
        model_step(r, l, s, p, t, pre);
        @(posedge clock);
        #1;
        check("count",       count_bcd,            to_bcd(m_secs));
        check("running",     {15'd0, running},     {15'd0, m_mode == M_RUN});
        check("tick_enable", {15'd0, tick_enable}, {15'd0, m_mode == M_RUN});
        check("done",        {15'd0, done},        {15'd0, m_mode == M_DONE});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        logic [15:0] rp;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        check("reset_count", count_bcd, 16'h0000);

        // Basic countdown from 0003.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0003);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
            check("cd_value", count_bcd, 16'(2 - k));
            idle(9);
        end
        check("cd_done", {15'd0, done}, 16'h0001);
        check("cd_ten",  {15'd0, tick_enable}, 16'h0000);

        // Full borrow across all digits.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        check("borrow_val", count_bcd, 16'h0959);
        check("borrow_run", {15'd0, running}, 16'h0001);
        idle(2);

        // Saturation, then start from zero.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFA7C);
        check("sat_val", count_bcd, 16'h9959);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        check("zero_done", {15'd0, done}, 16'h0001);
        check("zero_ten",  {15'd0, tick_enable}, 16'h0000);

        // Pause and tick filtering.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0105);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        end
        check("pause_hold", count_bcd, 16'h0105);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        check("level_once", count_bcd, 16'h0104);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        check("pause_wins", {15'd0, running}, 16'h0000);

        // Load beats a coincident tick; reset while running.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0042);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0030);
        check("prio_val", count_bcd, 16'h0030);
        check("prio_run", {15'd0, running}, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0115);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        check("rst_val", count_bcd, 16'h0000);
        check("rst_run", {15'd0, running}, 16'h0000);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                rp = {8'h00, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 11))};
            end else begin
                rp = 16'($urandom);
            end
            step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) == 0, rp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regressive_timer.md
Name: regressive_timer

Overview:
- Downstream consumer of the one-second tick generator in the regressive counter design.
- Holds a preset MM:SS value in BCD and counts it down once per second while running.
- Drives the upstream tick generator's enable.
- Flags completion at 00:00 and presents four BCD digits for the display decoders.

Parameters:
- MAX_MIN_TENS, 9, largest legal minutes-tens digit; a larger loaded value saturates to this.
- TICK_EDGE, 1, 1 = decrement on the rising edge of tick; 0 = decrement on every cycle tick is high.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- tick  in  1  one-second pulse from the upstream counter's finished output.
- load  in  1  latch preset_bcd and enter IDLE.
- start  in  1  begin or resume counting.
- pause  in  1  suspend counting.
- preset_bcd  in  16  {min_tens, min_units, sec_tens, sec_units}, 4 bits each.
- count_bcd  out  16  current value, same digit order.
- tick_enable  out  1  drives the upstream start input; high only in RUNNING.
- running  out  1  high in RUNNING.
- done  out  1  high in DONE.

Behaviour:
- Clock and reset: clock clock; reset reset, synchronous, active-high.
- Reset values:
  - count_bcd = 16'h0000; state = IDLE.
  - tick_enable = 0; running = 0; done = 0.
  - Tick edge register = 0.
- States: IDLE, RUNNING, PAUSED, DONE. Encoding lives in the package.
- Command priority: reset > load > pause > start > tick.
- load, from any state:
  - count_bcd <= saturated preset_bcd next cycle.
  - Next state = IDLE; done cleared.
- Saturation on load, per digit:
  - sec_units > 9 becomes 9; sec_tens > 5 becomes 5.
  - min_units > 9 becomes 9; min_tens > MAX_MIN_TENS becomes MAX_MIN_TENS.
- start:
  - In IDLE or PAUSED with count ≠ 0: go to RUNNING.
  - In IDLE or PAUSED with count == 0: go directly to DONE.
  - Ignored in RUNNING and DONE.
- pause:
  - In RUNNING: go to PAUSED; count_bcd is held.
  - Ignored elsewhere.
  - pause and start in the same cycle: pause wins.
- Tick qualification:
  - With TICK_EDGE=1, a tick is accepted when tick = 1 and the registered tick = 0. The edge register updates every cycle in every state.
  - An accepted tick acts only in RUNNING. A tick arriving in IDLE, PAUSED or DONE is discarded, never queued.
  - A tick coincident with pause or load is discarded.
- Decrement, one accepted tick:
  - sec_units - 1. If sec_units was 0, it becomes 9 and borrows from sec_tens.
  - sec_tens borrow: 0 becomes 5 and borrows from min_units.
  - min_units borrow: 0 becomes 9 and borrows from min_tens.
  - min_tens decrements on borrow. It never underflows, because the value is nonzero while RUNNING.
- Reaching zero: when the post-decrement value is 0000, the FSM enters DONE in the same cycle count_bcd becomes 0000.
  - done = 1 and tick_enable = 0 from the next cycle on.
- DONE is sticky until load or reset; count_bcd stays 0000.
- Output decoding: tick_enable and running are registered state decodes, with no combinational path from inputs.
- Latency:
  - load, start or pause to visible output: 1 cycle.
  - Accepted tick to count_bcd update: 1 cycle.
- Upstream timing: the upstream counter restarts its 50,000,000-cycle period only under its own reset. A resume after PAUSED therefore yields a first interval shorter than 1 s; this is accepted behaviour.
- Reset mid-RUNNING: all outputs return to reset values on the next edge.

Decomposition:
- Package regressive_timer_pkg:
  - State enum (IDLE, RUNNING, PAUSED, DONE).
  - SEC_TENS_MAX = 5 and DIGIT_MAX = 9.
  - Digit-field index constants.
- Sub-module bcd_down_digit, instantiated four times:
  - Parameter MAX_DIGIT.
  - Inputs: decrement enable, load enable, load value.
  - Outputs: digit, borrow_out (asserted when decrementing from 0).
  - Saturates the load value internally.
  - Borrows chain combinationally: sec_units to sec_tens to min_units to min_tens.
- Top level holds the FSM, tick edge detection and zero detection.

Test Plan:
- Basic countdown:
  - Stimulus: reset, load preset 16'h0003, start, then one-cycle tick pulses spaced 10 cycles apart.
  - Response: count 0002, 0001, 0000; done rises 1 cycle after the third tick; tick_enable falls with it.
- Full borrow:
  - Stimulus: load 16'h1000, start, one tick.
  - Response: count_bcd = 16'h0959; running stays 1.
- Saturation and zero start:
  - Stimulus: load 16'hFA7C.
  - Response: count_bcd = 16'h9959.
  - Then load 16'h0000 and start: DONE next cycle, tick_enable never asserts.
- Pause and tick filtering:
  - Stimulus: load 0105, start, then pause.
  - Ticks during PAUSED leave count unchanged.
  - tick held high for 5 cycles in RUNNING decrements exactly once.
  - start and pause asserted together from PAUSED: stays PAUSED.
- Priority and reset:
  - Stimulus: in RUNNING at 0042, assert tick and load 0030 in the same cycle.
  - Response: count = 0030, state IDLE.
  - Assert reset while RUNNING at 0115: next cycle all outputs are zero and state is IDLE.
